// File: rtl/mem_access_if.sv
// Bus bundle between the MEM stage, its upstream/downstream pipeline registers and the byte-wide RAM.
// The slave side is the MEM stage and the master side is its environment.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [4:0]            ex_wd;
    logic                  ex_wreg;
    logic [31:0]           ex_wdata;
    logic                  ex_mem_re;
    logic                  ex_mem_we;
    logic [2:0]            ex_funct3;
    logic [ADDR_WIDTH-1:0] ex_addr;
    logic [31:0]           ex_sdata;
    logic [7:0]            mem_din;

    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic                  mem_wr;
    logic [4:0]            mem_wd;
    logic                  mem_wreg;
    logic [31:0]           mem_wdata;
    logic                  stallreq;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_mem_re, ex_mem_we, ex_funct3,
               ex_addr, ex_sdata, mem_din,
        input  mem_a, mem_dout, mem_wr, mem_wd, mem_wreg, mem_wdata, stallreq
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_mem_re, ex_mem_we, ex_funct3,
               ex_addr, ex_sdata, mem_din,
        output mem_a, mem_dout, mem_wr, mem_wd, mem_wreg, mem_wdata, stallreq
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: ALU pass-through plus byte-serial loads and stores
// over an 8-bit RAM port, holding the front of the pipe while an access is in flight.
module mem_access #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [7:0]            r_buf [4];
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic                  r_is_load;

    logic [2:0]            w_n_in;
    logic [2:0]            w_n_reg;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_addr_k;
    logic [7:0]            w_store_byte;
    logic [31:0]           w_load_word;
    logic [31:0]           w_load_ext;
    logic                  w_wr_raw;
    logic [7:0]            w_dout_raw;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_n_in   = byte_count(bus.ex_funct3[1:0]);
    assign w_n_reg  = byte_count(r_funct3[1:0]);
    assign w_start  = bus.ex_mem_re | bus.ex_mem_we;
    assign w_addr_k = r_addr + ADDR_WIDTH'(r_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ex_mem_re) begin
                    w_state_next = S_LOAD;
                end else if (bus.ex_mem_we) begin
                    w_state_next = (w_n_in == 3'd1) ? S_DONE : S_STORE;
                end
            end
            S_LOAD: begin
                if (r_cnt >= w_n_reg) begin
                    w_state_next = S_DONE;
                end
            end
            S_STORE: begin
                if (r_cnt == 3'(w_n_reg - 3'd1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address and size are latched at IDLE so the access never depends on later input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_addr    <= '0;
            r_funct3  <= 3'd0;
            r_is_load <= 1'b0;
        end else if (rdy) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= 3'd1;
                        r_addr    <= bus.ex_addr;
                        r_funct3  <= bus.ex_funct3;
                        r_is_load <= bus.ex_mem_re;
                    end
                end
                S_LOAD: begin
                    if (r_cnt < w_n_reg) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_STORE: r_cnt <= r_cnt + 3'd1;
                default: ;
            endcase
        end
    end

    // Byte gi of a load arrives in the LOAD cycle whose counter is gi+1.
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (rst) begin
                r_buf[gi] <= 8'd0;
            end else if (rdy && r_state == S_LOAD && r_cnt == 3'(gi + 1)) begin
                r_buf[gi] <= bus.mem_din;
            end
        end
    end

    assign w_load_word = {r_buf[3], r_buf[2], r_buf[1], r_buf[0]};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_load_word[7]}}, w_load_word[7:0]};
            3'b001:  w_load_ext = {{16{w_load_word[15]}}, w_load_word[15:0]};
            3'b100:  w_load_ext = {24'd0, w_load_word[7:0]};
            3'b101:  w_load_ext = {16'd0, w_load_word[15:0]};
            default: w_load_ext = w_load_word;
        endcase
    end

    always_comb begin
        case (r_cnt[1:0])
            2'd1:    w_store_byte = bus.ex_sdata[15:8];
            2'd2:    w_store_byte = bus.ex_sdata[23:16];
            2'd3:    w_store_byte = bus.ex_sdata[31:24];
            default: w_store_byte = bus.ex_sdata[7:0];
        endcase
    end

    always_comb begin
        bus.mem_a     = '0;
        bus.mem_wd    = 5'd0;
        bus.mem_wreg  = 1'b0;
        bus.mem_wdata = 32'd0;
        bus.stallreq  = 1'b0;
        w_wr_raw      = 1'b0;
        w_dout_raw    = 8'd0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        bus.mem_a    = bus.ex_addr;
                        bus.stallreq = 1'b1;
                        if (!bus.ex_mem_re) begin
                            w_wr_raw   = 1'b1;
                            w_dout_raw = bus.ex_sdata[7:0];
                        end
                    end else begin
                        bus.mem_wd    = bus.ex_wd;
                        bus.mem_wreg  = bus.ex_wreg;
                        bus.mem_wdata = bus.ex_wdata;
                    end
                end
                S_LOAD: begin
                    bus.stallreq = 1'b1;
                    if (r_cnt < w_n_reg) begin
                        bus.mem_a = w_addr_k;
                    end
                end
                S_STORE: begin
                    bus.stallreq = 1'b1;
                    bus.mem_a    = w_addr_k;
                    w_wr_raw     = 1'b1;
                    w_dout_raw   = w_store_byte;
                end
                S_DONE: begin
                    bus.mem_wd    = bus.ex_wd;
                    bus.mem_wreg  = bus.ex_wreg;
                    bus.mem_wdata = r_is_load ? w_load_ext : bus.ex_wdata;
                end
                default: ;
            endcase
        end
    end

    // A frozen pipeline must not strobe the RAM, otherwise a byte would be written twice.
    assign bus.mem_wr   = w_wr_raw & rdy;
    assign bus.mem_dout = bus.mem_wr ? w_dout_raw : 8'd0;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a byte RAM model, expected write-back and RAM-write queues,
// and a per-instruction driver that also checks stall length, write count and read addresses.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_WIDTH(32)) bus ();

    mem_access #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_t;

    wb_t         wb_q [$];
    logic [39:0] wr_q [$];
    logic [7:0]  ram [logic [31:0]];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM model: read data is valid one cycle after the address is presented.
    always @(posedge clk) begin
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    always @(negedge clk) begin : monitor
        wb_t         e;
        logic [39:0] w;
        if (!rst && rdy && !bus.stallreq) begin
            if (wb_q.size() == 0) begin
                check_val("wb_underflow", 32'd1, 32'd0);
            end else begin
                e = wb_q.pop_front();
                check_val("mem_wd", 32'(bus.mem_wd), 32'(e.wd));
                check_val("mem_wreg", 32'(bus.mem_wreg), 32'(e.wreg));
                check_val("mem_wdata", bus.mem_wdata, e.wdata);
                $display("retire wd=%0d wreg=%0b wdata=%h", bus.mem_wd, bus.mem_wreg, bus.mem_wdata);
            end
        end
        if (bus.mem_wr) begin
            if (wr_q.size() == 0) begin
                check_val("wr_underflow", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                check_val("wr_addr", bus.mem_a, w[39:8]);
                check_val("wr_data", 32'(bus.mem_dout), 32'(w[7:0]));
                $display("ram write a=%h d=%h", bus.mem_a, bus.mem_dout);
            end
        end
    end

    task automatic check_zero();
        check_val("rst_mem_a", bus.mem_a, 32'd0);
        check_val("rst_misc", 32'({bus.mem_dout, bus.mem_wr, bus.mem_wd, bus.mem_wreg, bus.stallreq}), 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'd0);
    endtask

    // Called just after a rising edge; returns just after the edge that retires the instruction.
    task automatic do_instr(input logic re, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] wd, input logic wreg, input logic [31:0] alu,
                            input logic [31:0] exp_wdata, input int drop_after, input int rst_after);
        wb_t e;
        int  n, exp_stall, exp_pulses;
        int  stall = 0, pulses = 0, lk = 0, rhold = 0, dhold = 0;
        bit  done = 0, dropped = 0, resetted = 0;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        exp_stall  = re ? n + 1 : (we ? n : 0);
        exp_pulses = we ? n : 0;
        bus.ex_mem_re = re;
        bus.ex_mem_we = we;
        bus.ex_funct3 = f3;
        bus.ex_addr   = addr;
        bus.ex_sdata  = sdata;
        bus.ex_wd     = wd;
        bus.ex_wreg   = wreg;
        bus.ex_wdata  = alu;
        e.wd = wd;
        e.wreg = wreg;
        e.wdata = exp_wdata;
        wb_q.push_back(e);
        if (we) begin
            for (int k = 0; k < n; k++) wr_q.push_back({addr + 32'(k), sdata[8*k +: 8]});
        end
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (rst) begin
                check_zero();
            end else begin
                if (bus.mem_wr) pulses++;
                if (rdy) begin
                    if (bus.stallreq) begin
                        if (re && lk < n) begin
                            check_val("rd_addr", bus.mem_a, addr + 32'(lk));
                            lk++;
                        end
                        stall++;
                    end else begin
                        done = 1;
                        if (!re && !we) begin
                            check_val("alu_mem_a", bus.mem_a, 32'd0);
                            check_val("alu_mem_wr", 32'(bus.mem_wr), 32'd0);
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rhold > 0) begin
                rhold--;
                if (rhold == 0) rst = 1'b0;
            end else if (rst_after >= 0 && !resetted && !done && stall == rst_after) begin
                rst = 1'b1;
                rhold = 2;
                resetted = 1;
                stall = 0;
                lk = 0;
            end
            if (dhold > 0) begin
                dhold--;
                if (dhold == 0) rdy = 1'b1;
            end else if (drop_after >= 0 && !dropped && pulses == drop_after) begin
                rdy = 1'b0;
                dropped = 1;
                dhold = 3;
            end
        end
        if (!done) check_val("timeout", 32'd0, 32'd1);
        check_val("stall_cycles", 32'(stall), 32'(exp_stall));
        check_val("wr_pulses", 32'(pulses), 32'(exp_pulses));
        $display("instr re=%0b we=%0b f3=%b addr=%h stall=%0d pulses=%0d", re, we, f3, addr, stall, pulses);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ram[32'h100] = 8'h78;
        ram[32'h101] = 8'h56;
        ram[32'h102] = 8'h34;
        ram[32'h103] = 8'h12;
        ram[32'h203] = 8'h80;
        ram[32'h000] = 8'h99;
        rst = 1'b1;
        rdy = 1'b1;
        bus.ex_mem_re = 1'b1;
        bus.ex_mem_we = 1'b0;
        bus.ex_funct3 = 3'b010;
        bus.ex_addr   = 32'h100;
        bus.ex_sdata  = 32'hFFFF_FFFF;
        bus.ex_wd     = 5'd9;
        bus.ex_wreg   = 1'b1;
        bus.ex_wdata  = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_instr(1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         5'd5,  1'b1, 32'h1234,     32'h1234,     -1, -1);
        do_instr(1'b1, 1'b0, 3'b010, 32'h100,       32'h0,         5'd3,  1'b1, 32'h100,      32'h12345678, -1, -1);
        do_instr(1'b1, 1'b0, 3'b000, 32'h203,       32'h0,         5'd4,  1'b1, 32'h203,      32'hFFFFFF80, -1, -1);
        do_instr(1'b1, 1'b0, 3'b100, 32'h203,       32'h0,         5'd4,  1'b1, 32'h203,      32'h00000080, -1, -1);
        do_instr(1'b0, 1'b1, 3'b001, 32'h7FFF,      32'hABCD,      5'd0,  1'b0, 32'h7FFF,     32'h7FFF,     -1, -1);
        do_instr(1'b1, 1'b0, 3'b101, 32'h7FFF,      32'h0,         5'd6,  1'b1, 32'h7FFF,     32'h0000ABCD, -1, -1);
        do_instr(1'b1, 1'b0, 3'b001, 32'h7FFF,      32'h0,         5'd6,  1'b1, 32'h7FFF,     32'hFFFFABCD, -1, -1);
        do_instr(1'b0, 1'b1, 3'b010, 32'h400,       32'hDEADBEEF,  5'd7,  1'b1, 32'h55,       32'h55,        2, -1);
        do_instr(1'b1, 1'b0, 3'b010, 32'h400,       32'h0,         5'd8,  1'b1, 32'h400,      32'hDEADBEEF, -1, -1);
        do_instr(1'b0, 1'b1, 3'b000, 32'hFFFFFFFF,  32'h11223344,  5'd8,  1'b1, 32'h0BAD,     32'h0BAD,     -1, -1);
        do_instr(1'b1, 1'b0, 3'b001, 32'hFFFFFFFF,  32'h0,         5'd9,  1'b1, 32'h0,        32'hFFFF9944, -1, -1);
        do_instr(1'b1, 1'b0, 3'b010, 32'h100,       32'h0,         5'd10, 1'b1, 32'h100,      32'h12345678, -1,  2);
        do_instr(1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         5'd31, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, -1, -1);

        rdy = 1'b0;
        @(negedge clk);
        check_val("wb_q_empty", 32'(wb_q.size()), 32'd0);
        check_val("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
